// File: rtl/alu_result_seg7_scan_if.sv
// alu_result_seg7_scan_if
//   Bundles the ALU-result handshake and the display outputs of
//   alu_result_seg7_scan.
//   ena          : design enable (low freezes everything, blanks display)
//   result       : 8-bit ALU result word
//   result_valid : single-cycle strobe qualifying result
//   seg          : 7-segment drive, active-high, seg[0]=a .. seg[6]=g
//   dp           : decimal point, active-high (marks the high digit)
//   busy         : high once a first result has been captured
//   overrun      : sticky, a queued result was overwritten
`timescale 1ns/1ps
interface alu_result_seg7_scan_if;
  logic       ena;
  logic [7:0] result;
  logic       result_valid;
  logic [6:0] seg;
  logic       dp;
  logic       busy;
  logic       overrun;

  modport master (
    output ena, result, result_valid,
    input  seg, dp, busy, overrun
  );

  modport slave (
    input  ena, result, result_valid,
    output seg, dp, busy, overrun
  );
endinterface

// File: rtl/alu_result_seg7_scan.sv
// alu_result_seg7_scan
//   Shows each captured 8-bit ALU result on one 7-segment display as a
//   repeating frame: high nibble (dp on), blank, low nibble, blank.
//   Results arriving mid-frame wait in a one-deep queue until the next
//   frame boundary so a digit pair is never torn.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : alu_result_seg7_scan_if.slave (ena, result, result_valid in;
//           seg, dp, busy, overrun out, all registered)
`timescale 1ns/1ps
module alu_result_seg7_scan #(
  parameter int DIGIT_CYCLES = 10_000_000,
  parameter int GAP_CYCLES   = 2_500_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_result_seg7_scan_if.slave bus
);

  localparam int MAX_N = (DIGIT_CYCLES > GAP_CYCLES) ? DIGIT_CYCLES : GAP_CYCLES;
  localparam int CNT_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [6:0]       SEG_DASH   = 7'b1000000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HI,
    S_GAP1,
    S_LO,
    S_GAP2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]       r_cur, w_cur_nxt;
  logic [7:0]       r_pend, w_pend_nxt;
  logic             r_pend_flag, w_pend_flag_nxt;
  logic             r_overrun, w_overrun_nxt;
  logic [6:0]       r_seg, w_seg_nxt;
  logic             r_dp, w_dp_nxt;
  logic             r_busy, w_busy_nxt;
  logic             w_last;
  logic             w_boundary;

  // Segment pattern (g..a) for one hex digit.
  function automatic logic [6:0] hex7(input logic [3:0] d);
    case (d)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  // Digit states and gap states have different lengths.
  assign w_last = ((r_state == S_HI) || (r_state == S_LO)) ? (r_cnt == DIGIT_LAST)
                                                           : (r_cnt == GAP_LAST);
  assign w_boundary = (r_state == S_GAP2) && w_last;

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_cur_nxt       = r_cur;
    w_pend_nxt      = r_pend;
    w_pend_flag_nxt = r_pend_flag;
    w_overrun_nxt   = r_overrun;
    w_seg_nxt       = '0;
    w_dp_nxt        = 1'b0;
    w_busy_nxt      = r_busy;

    if (bus.ena) begin
      if (r_state == S_IDLE) begin
        if (bus.result_valid) begin
          w_state_nxt = S_HI;
          w_cur_nxt   = bus.result;
          w_cnt_nxt   = '0;
        end
      end else begin
        if (w_last) begin
          w_cnt_nxt = '0;
          case (r_state)
            S_HI:    w_state_nxt = S_GAP1;
            S_GAP1:  w_state_nxt = S_LO;
            S_LO:    w_state_nxt = S_GAP2;
            default: w_state_nxt = S_HI;
          endcase
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end

        // A strobe on the boundary edge goes straight to display and
        // supersedes any queued value without counting as an overrun.
        if (bus.result_valid) begin
          if (w_boundary) begin
            w_cur_nxt       = bus.result;
            w_pend_flag_nxt = 1'b0;
          end else begin
            w_pend_nxt      = bus.result;
            w_pend_flag_nxt = 1'b1;
            if (r_pend_flag) begin
              w_overrun_nxt = 1'b1;
            end
          end
        end else if (w_boundary && r_pend_flag) begin
          w_cur_nxt       = r_pend;
          w_pend_flag_nxt = 1'b0;
        end
      end

      // Outputs follow the state being entered so they change on that edge.
      w_busy_nxt = (w_state_nxt != S_IDLE);
      case (w_state_nxt)
        S_IDLE: w_seg_nxt = SEG_DASH;
        S_HI: begin
          w_seg_nxt = hex7(w_cur_nxt[7:4]);
          w_dp_nxt  = 1'b1;
        end
        S_LO:    w_seg_nxt = hex7(w_cur_nxt[3:0]);
        default: w_seg_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_cur       <= '0;
      r_pend      <= '0;
      r_pend_flag <= 1'b0;
      r_overrun   <= 1'b0;
      r_seg       <= '0;
      r_dp        <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cur       <= w_cur_nxt;
      r_pend      <= w_pend_nxt;
      r_pend_flag <= w_pend_flag_nxt;
      r_overrun   <= w_overrun_nxt;
      r_seg       <= w_seg_nxt;
      r_dp        <= w_dp_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign bus.seg     = r_seg;
  assign bus.dp      = r_dp;
  assign bus.busy    = r_busy;
  assign bus.overrun = r_overrun;

endmodule
